cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
//  Instruction fetch/execute controller for the Full_CPU. Sits directly downstream of
//  timing_generator: consumes its step/clk_s0/clk_s1 phase strobes and drives its E input
//  (run_en). Holds PC, IR and ACC, and drives a unified 2^ADDR_W x DATA_W memory.
//  One instruction = one 4-phase machine cycle: fetch in phases 0-1, execute in phases 2-3.
// PARAMETERS
//  ADDR_W    4   memory address / instruction operand width
//  DATA_W    8   data, ACC and instruction width; must equal 4+ADDR_W
//  PC_RESET  0   PC value loaded on reset
// PORTS
//  clk         in   1        system clock; all state updates on posedge
//  rst         in   1        asynchronous, active-high reset
//  start       in   1        level; IDLE->RUN when sampled high in IDLE
//  step        in   1        from timing_generator: 0=fetch half, 1=execute half
//  clk_s0      in   1        from timing_generator: fetch strobe (phase 1)
//  clk_s1      in   1        from timing_generator: execute strobe (phase 3)
//  run_en      out  1        to timing_generator E; 1 only in RUN
//  mem_addr    out  ADDR_W   PC when step=0, IR[ADDR_W-1:0] when step=1
//  mem_rdata   in   DATA_W   combinational read data for mem_addr
//  mem_wdata   out  DATA_W   = ACC
//  mem_we      out  1        write strobe; memory writes on the posedge where mem_we=1
//  pc,ir,acc   out  ADDR_W/DATA_W/DATA_W  architectural registers (debug/observe)
//  zero        out  1        (acc == 0), combinational
//  halted      out  1        1 in HALT
//  illegal_op  out  1        1-clk pulse on execute of an undefined opcode
// BEHAVIOUR
//  Reset (async, immediate): pc=PC_RESET, ir=0, acc=0, state=IDLE; run_en=0, mem_we=0,
//   halted=0, illegal_op=0.
//  FSM: IDLE -(start)-> RUN -(HLT executed)-> HALT. HALT exits only via rst; start ignored
//   in RUN/HALT.
//  Fetch edge (state RUN, clk_s0=1, step=0): ir<=mem_rdata; pc<=pc+1 (mod 2^ADDR_W, wraps).
//  Execute edge (state RUN, clk_s1=1, step=1); opcode=ir[DATA_W-1:ADDR_W], op=operand:
//   0 NOP: none | 1 LDA: acc<=mem[op] | 2 ADD: acc<=acc+mem[op] | 3 SUB: acc<=acc-mem[op]
//   4 STA: mem_we=1 this clk only, mem[op]<=acc | 5 JMP: pc<=op | 6 JZ: if zero pc<=op
//   7 HLT: state<=HALT | 8-15: treated as NOP, illegal_op=1 for this clk.
//  Arithmetic modulo 2^DATA_W; no carry/overflow kept. JZ tests acc before this edge.
//  mem_we, illegal_op combinational from state/strobes/opcode; never high outside an execute
//   edge in RUN.
//  run_en=(state==RUN) combinational; after HLT the generator wraps to phase 0 and parks.
//  No strobe activity in IDLE/HALT changes pc/ir/acc. clk_s0 and clk_s1 mutually exclusive
//   by construction; strobe with wrong step level is ignored.
//  Latency: 4 clk per instruction with E continuously high; first fetch 2 clk after the
//   IDLE->RUN edge.
//  rst mid-instruction: all state cleared immediately; a pending STA does not write.
// STRUCTURE
//  cpu_pkg: opcode localparams (OP_NOP..OP_HLT), FSM state encodings (S_IDLE/S_RUN/S_HALT).
//  Sub-module cpu_alu: combinational pass/add/sub on DATA_W operands selected by opcode.
//  Top: FSM, PC/IR/ACC registers, address mux, strobe qualification.
// TESTING
//  1 rst=1 at any time -> pc=0, ir=0, acc=0, run_en=0, halted=0, mem_we=0 immediately.
//  2 mem[0..3]=1E,2F,4D,70; mem[E]=05, mem[F]=03; start -> mem[D]=08, acc=08, pc=4,
//    halted=1, run_en=0; 4 clk per instruction.
//  3 mem[0..3]=1E,3E,66,70; mem[6]=70; mem[E]=05 -> JZ taken, halt with pc=7, acc=00, zero=1.
//  4 acc=FF, ADD of 02 -> acc=01; JMP F with mem[F]=00 -> next fetch from address 0 (pc wrap).
//  5 opcode A0 executed -> illegal_op high exactly 1 clk, acc unchanged, pc advances by 1.
//  6 rst pulse during phase 2 of an STA -> no memory write, state IDLE; start in HALT ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode values and FSM state type for the cpu_sequencer slice.
package cpu_pkg;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_LDA = 4'd1;
   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_SUB = 4'd3;
   localparam logic [3:0] OP_STA = 4'd4;
   localparam logic [3:0] OP_JMP = 4'd5;
   localparam logic [3:0] OP_JZ  = 4'd6;
   localparam logic [3:0] OP_HLT = 4'd7;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_HALT
   } state_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational accumulator datapath: pass-through load, add and subtract.
module cpu_alu
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic [3:0]        opcode,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] y
);

   always_comb begin
      y = a;
      case (opcode)
         OP_LDA:  y = b;
         OP_ADD:  y = a + b;
         OP_SUB:  y = a - b;
         default: y = a;
      endcase
   end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/execute controller: one instruction per 4-phase cycle of timing_generator.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 4,
   parameter int unsigned       DATA_W   = 8,
   parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              step,
   input  logic              clk_s0,
   input  logic              clk_s1,
   output logic              run_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] ir,
   output logic [DATA_W-1:0] acc,
   output logic              zero,
   output logic              halted,
   output logic              illegal_op
);

   state_t              state, state_next;
   logic                fetch, exec;
   logic [3:0]          opcode;
   logic [ADDR_W-1:0]   operand;
   logic [DATA_W-1:0]   alu_y;

   assign opcode  = ir[DATA_W-1:ADDR_W];
   assign operand = ir[ADDR_W-1:0];

   // A strobe only counts when its step level matches and the FSM is running.
   assign fetch = (state == S_RUN) && clk_s0 && !step;
   assign exec  = (state == S_RUN) && clk_s1 && step;

   assign mem_addr  = step ? operand : pc;
   assign mem_wdata = acc;
   assign zero      = (acc == '0);

   cpu_alu #(.DATA_W(DATA_W)) u_alu (
      .opcode (opcode),
      .a      (acc),
      .b      (mem_rdata),
      .y      (alu_y)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      run_en     = 1'b0;
      halted     = 1'b0;
      mem_we     = 1'b0;
      illegal_op = 1'b0;
      case (state)
         S_IDLE: if (start) state_next = S_RUN;
         S_RUN: begin
            run_en = 1'b1;
            if (exec) begin
               mem_we     = (opcode == OP_STA);
               illegal_op = opcode[3];
               if (opcode == OP_HLT) state_next = S_HALT;
            end
         end
         S_HALT: halted = 1'b1;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc  <= PC_RESET;
         ir  <= '0;
         acc <= '0;
      end else if (fetch) begin
         ir <= mem_rdata;
         pc <= pc + ADDR_W'(1);
      end else if (exec) begin
         case (opcode)
            OP_LDA, OP_ADD, OP_SUB: acc <= alu_y;
            OP_JMP:                 pc  <= operand;
            OP_JZ:                  if (zero) pc <= operand;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench: program table plus reset/halt corner sequences for cpu_sequencer.
module tb_cpu_sequencer;

   typedef struct {
      string            name;
      logic [15:0][7:0] img;
      logic [7:0]       exp_acc;
      logic [3:0]       exp_pc;
      logic             exp_zero;
      logic [3:0]       chk_addr;
      logic [7:0]       chk_data;
      int               exp_cycles;
      int               exp_we;
      int               exp_ill;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst, start, step, clk_s0, clk_s1;
   logic       run_en, mem_we, zero, halted, illegal_op;
   logic [3:0] mem_addr, pc;
   logic [7:0] mem_rdata, mem_wdata, ir, acc;

   logic [7:0]       mem [16];
   logic [15:0][7:0] load_img;
   logic             load;
   logic [1:0]       phase;
   logic             cnt_clr;
   int               we_cnt, ill_cnt;
   int               ncmp = 0;
   int               nfail = 0;
   vec_t             vecs [4];

   always #5 clk = ~clk;

   // timing_generator model: advances while E is high, wraps to phase 0 and parks.
   always @(posedge clk or posedge rst) begin
      if (rst) phase <= 2'd0;
      else if (run_en || phase != 2'd0) phase <= phase + 2'd1;
   end
   assign step   = phase[1];
   assign clk_s0 = (phase == 2'd1);
   assign clk_s1 = (phase == 2'd3);

   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < 16; i++) mem[i] <= load_img[i];
      end else if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   always @(negedge clk) begin
      if (cnt_clr) begin
         we_cnt  <= 0;
         ill_cnt <= 0;
      end else begin
         if (mem_we)     we_cnt  <= we_cnt + 1;
         if (illegal_op) ill_cnt <= ill_cnt + 1;
      end
   end

   cpu_sequencer #(.ADDR_W(4), .DATA_W(8), .PC_RESET(4'h0)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .step       (step),
      .clk_s0     (clk_s0),
      .clk_s1     (clk_s1),
      .run_en     (run_en),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .pc         (pc),
      .ir         (ir),
      .acc        (acc),
      .zero       (zero),
      .halted     (halted),
      .illegal_op (illegal_op)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic reset_and_load(input logic [15:0][7:0] img);
      @(negedge clk);
      rst      = 1'b1;
      start    = 1'b0;
      load_img = img;
      load     = 1'b1;
      cnt_clr  = 1'b1;
      @(negedge clk);
      load    = 1'b0;
      rst     = 1'b0;
      cnt_clr = 1'b0;
   endtask

   task automatic run_to_halt(input string name, output int cycles);
      cycles = 0;
      @(negedge clk);
      start = 1'b1;
      while (cycles < 200) begin
         @(posedge clk);
         #1;
         cycles++;
         if (halted) break;
      end
      start = 1'b0;
      if (!halted) begin
         ncmp++;
         nfail++;
         $display("FAIL %s_timeout: got no halt expected halt within 200 clk", name);
      end
   endtask

   function automatic logic [15:0][7:0] mk_img(input logic [7:0] b [16]);
      logic [15:0][7:0] r;
      for (int i = 0; i < 16; i++) r[i] = b[i];
      return r;
   endfunction

   initial begin
      logic [7:0] b [16];
      int         cycles;
      int         waited;
      logic [3:0] pc_hold;

      rst = 1'b1; start = 1'b0; load = 1'b0; cnt_clr = 1'b1;
      load_img = '0;
      #1;
      chk("rst_pc", 32'(pc), 32'h0);
      chk("rst_ir", 32'(ir), 32'h0);
      chk("rst_acc", 32'(acc), 32'h0);
      chk("rst_run_en", 32'(run_en), 32'h0);
      chk("rst_halted", 32'(halted), 32'h0);
      chk("rst_mem_we", 32'(mem_we), 32'h0);

      // LDA E; ADD F; STA D; HLT
      b = '{default: 8'h00};
      b[0] = 8'h1E; b[1] = 8'h2F; b[2] = 8'h4D; b[3] = 8'h70; b[14] = 8'h05; b[15] = 8'h03;
      vecs[0] = '{"add_sta", mk_img(b), 8'h08, 4'h4, 1'b0, 4'hD, 8'h08, 17, 1, 0};
      // LDA E; SUB E; JZ 6; (skipped) ; HLT at 6
      b = '{default: 8'h00};
      b[0] = 8'h1E; b[1] = 8'h3E; b[2] = 8'h66; b[3] = 8'h70; b[6] = 8'h70; b[14] = 8'h05;
      vecs[1] = '{"jz_taken", mk_img(b), 8'h00, 4'h7, 1'b1, 4'hE, 8'h05, 17, 0, 0};
      // JZ C; HLT | C: LDA A(FF); ADD B(02); JMP F; F: NOP -> pc wraps to 0, JZ falls through
      b = '{default: 8'h00};
      b[0] = 8'h6C; b[1] = 8'h70; b[10] = 8'hFF; b[11] = 8'h02;
      b[12] = 8'h1A; b[13] = 8'h2B; b[14] = 8'h5F; b[15] = 8'h00;
      vecs[2] = '{"wrap_add", mk_img(b), 8'h01, 4'h2, 1'b0, 4'hF, 8'h00, 29, 0, 0};
      // LDA E; A0 (illegal); HLT
      b = '{default: 8'h00};
      b[0] = 8'h1E; b[1] = 8'hA0; b[2] = 8'h70; b[14] = 8'h05;
      vecs[3] = '{"illegal", mk_img(b), 8'h05, 4'h3, 1'b0, 4'hE, 8'h05, 13, 0, 1};

      for (int unsigned v = 0; v < 4; v++) begin
         reset_and_load(vecs[v].img);
         run_to_halt(vecs[v].name, cycles);
         @(negedge clk);
         chk({vecs[v].name, "_acc"}, 32'(acc), 32'(vecs[v].exp_acc));
         chk({vecs[v].name, "_pc"}, 32'(pc), 32'(vecs[v].exp_pc));
         chk({vecs[v].name, "_zero"}, 32'(zero), 32'(vecs[v].exp_zero));
         chk({vecs[v].name, "_halted"}, 32'(halted), 32'h1);
         chk({vecs[v].name, "_run_en"}, 32'(run_en), 32'h0);
         chk({vecs[v].name, "_mem"}, 32'(mem[vecs[v].chk_addr]), 32'(vecs[v].chk_data));
         chk({vecs[v].name, "_cycles"}, 32'(cycles), 32'(vecs[v].exp_cycles));
         chk({vecs[v].name, "_we_cnt"}, 32'(we_cnt), 32'(vecs[v].exp_we));
         chk({vecs[v].name, "_ill_cnt"}, 32'(ill_cnt), 32'(vecs[v].exp_ill));
      end

      // start held high in HALT must not restart or move anything
      pc_hold = pc;
      start = 1'b1;
      repeat (12) @(negedge clk);
      start = 1'b0;
      chk("halt_start_halted", 32'(halted), 32'h1);
      chk("halt_start_run_en", 32'(run_en), 32'h0);
      chk("halt_start_pc", 32'(pc), 32'(pc_hold));

      // rst during phase 2 of STA: immediate clear, no write
      reset_and_load(vecs[0].img);
      @(negedge clk);
      start = 1'b1;
      waited = 0;
      while (!(phase == 2'd2 && ir == 8'h4D) && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      start = 1'b0;
      chk("sta_phase2_reached", 32'(ir), 32'h4D);
      chk("sta_acc_before_rst", 32'(acc), 32'h08);
      rst = 1'b1;
      #1;
      chk("midrst_pc", 32'(pc), 32'h0);
      chk("midrst_ir", 32'(ir), 32'h0);
      chk("midrst_acc", 32'(acc), 32'h0);
      chk("midrst_run_en", 32'(run_en), 32'h0);
      chk("midrst_mem_we", 32'(mem_we), 32'h0);
      chk("midrst_halted", 32'(halted), 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("midrst_no_write", 32'(mem[13]), 32'h00);
      chk("midrst_we_cnt", 32'(we_cnt), 32'h0);
      chk("midrst_idle_run_en", 32'(run_en), 32'h0);
      chk("midrst_idle_pc", 32'(pc), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
